// File: rtl/ifsram_pingpong_ctrl_if.sv
// rtl/ifsram_pingpong_ctrl_if.sv - stream, read-port and SRAM signal bundle for ifsram_pingpong_ctrl
// err_sticky exists only when IFSRAM_PP_ERR_EN is defined.
interface ifsram_pingpong_ctrl_if #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 11
);
   logic              start_if_store;
   logic [ADDR_W:0]   store_len;
   logic              if_store_busy;
   logic              if_store_done;
   logic [DATA_W-1:0] ifstore_data_din;
   logic              ifstore_empty_n_din;
   logic              ifstore_read_dout;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_release;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic [1:0]        bank_full;
   logic              cen_b0, cen_b1, wen_b0, wen_b1;
   logic [ADDR_W-1:0] addr_b0, addr_b1;
   logic [DATA_W-1:0] din_b0, din_b1, dout_b0, dout_b1;
`ifdef IFSRAM_PP_ERR_EN
   logic              err_sticky;
`endif

   modport slave (
`ifdef IFSRAM_PP_ERR_EN
      output err_sticky,
`endif
      input  start_if_store, store_len, ifstore_data_din, ifstore_empty_n_din,
      input  rd_en, rd_addr, rd_release, dout_b0, dout_b1,
      output if_store_busy, if_store_done, ifstore_read_dout, rd_data, rd_valid, bank_full,
      output cen_b0, cen_b1, wen_b0, wen_b1, addr_b0, addr_b1, din_b0, din_b1
   );

   modport master (
`ifdef IFSRAM_PP_ERR_EN
      input  err_sticky,
`endif
      output start_if_store, store_len, ifstore_data_din, ifstore_empty_n_din,
      output rd_en, rd_addr, rd_release, dout_b0, dout_b1,
      input  if_store_busy, if_store_done, ifstore_read_dout, rd_data, rd_valid, bank_full,
      input  cen_b0, cen_b1, wen_b0, wen_b1, addr_b0, addr_b1, din_b0, din_b1
   );
endinterface

// File: rtl/ifsram_pingpong_ctrl.sv
// rtl/ifsram_pingpong_ctrl.sv - two-bank ping-pong SRAM controller: stream fill writer, tile reader
// Optional IFSRAM_PP_ERR_EN adds a sticky protocol-error flag.
module ifsram_pingpong_ctrl #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 11
) (
   input  logic                 clk,
   input  logic                 reset,
   ifsram_pingpong_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, WAIT_BANK, FILL, DONE} state_t;
   localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

   state_t            state_q, state_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
   logic              wr_bank_q, wr_bank_d;
   logic              rd_bank_q, rd_bank_d;
   logic [1:0]        bank_full_q, bank_full_d;
   logic              done_q, done_d;
   logic              wr_vld_q, wr_vld_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic              rd_valid_q, rd_valid_d;
   logic              rd_sel_q, rd_sel_d;
   logic              set_pend_q, set_pend_d;
   logic              pend_bank_q, pend_bank_d;

   logic              beat, rd_hit, rel_hit, set_now;
   logic [ADDR_W:0]   cnt_inc;

   assign beat    = (state_q == FILL) && bus.ifstore_empty_n_din && (word_cnt_q < len_q);
   assign rd_hit  = bus.rd_en && bank_full_q[rd_bank_q];
   assign rel_hit = bus.rd_release && bank_full_q[rd_bank_q];
   assign cnt_inc = word_cnt_q + CNT_ONE;
   assign set_now = (state_q == DONE) && (len_q != '0);

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      word_cnt_d  = word_cnt_q;
      wr_bank_d   = wr_bank_q;
      done_d      = 1'b0;
      wr_vld_d    = beat;
      wr_addr_d   = word_cnt_q[ADDR_W-1:0];
      wr_data_d   = bus.ifstore_data_din;
      case (state_q)
         IDLE: begin
            word_cnt_d = '0;
            if (bus.start_if_store) begin
               len_d = bus.store_len;
               if (bus.store_len == '0) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else if (bank_full_q[wr_bank_q]) begin
                  state_d = WAIT_BANK;
               end else begin
                  state_d = FILL;
               end
            end
         end
         WAIT_BANK: begin
            if (!bank_full_q[wr_bank_q]) state_d = FILL;
         end
         FILL: begin
            if (beat) begin
               word_cnt_d = cnt_inc;
               if (cnt_inc == len_q) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            if (set_now) wr_bank_d = ~wr_bank_q;
         end
      endcase
   end

   // A release that frees the bank being marked full wins; the set is replayed next cycle.
   always_comb begin
      bank_full_d = bank_full_q;
      rd_bank_d   = rd_bank_q;
      set_pend_d  = 1'b0;
      pend_bank_d = pend_bank_q;
      rd_valid_d  = rd_hit;
      rd_sel_d    = rd_bank_q;
      if (set_pend_q) bank_full_d[pend_bank_q] = 1'b1;
      if (rel_hit) begin
         bank_full_d[rd_bank_q] = 1'b0;
         rd_bank_d              = ~rd_bank_q;
      end
      if (set_now) begin
         if (rel_hit && (rd_bank_q == wr_bank_q)) begin
            set_pend_d  = 1'b1;
            pend_bank_d = wr_bank_q;
         end else begin
            bank_full_d[wr_bank_q] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         len_q       <= '0;
         word_cnt_q  <= '0;
         wr_bank_q   <= 1'b0;
         rd_bank_q   <= 1'b0;
         bank_full_q <= 2'b00;
         done_q      <= 1'b0;
         wr_vld_q    <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         rd_valid_q  <= 1'b0;
         rd_sel_q    <= 1'b0;
         set_pend_q  <= 1'b0;
         pend_bank_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         word_cnt_q  <= word_cnt_d;
         wr_bank_q   <= wr_bank_d;
         rd_bank_q   <= rd_bank_d;
         bank_full_q <= bank_full_d;
         done_q      <= done_d;
         wr_vld_q    <= wr_vld_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         rd_valid_q  <= rd_valid_d;
         rd_sel_q    <= rd_sel_d;
         set_pend_q  <= set_pend_d;
         pend_bank_q <= pend_bank_d;
      end
   end

   // Reader and writer never target the same bank: one is full, the other is being filled.
   always_comb begin
      bus.cen_b0  = 1'b1;
      bus.wen_b0  = 1'b1;
      bus.addr_b0 = '0;
      bus.din_b0  = '0;
      bus.cen_b1  = 1'b1;
      bus.wen_b1  = 1'b1;
      bus.addr_b1 = '0;
      bus.din_b1  = '0;
      if (wr_vld_q) begin
         if (wr_bank_q) begin
            bus.cen_b1  = 1'b0;
            bus.wen_b1  = 1'b0;
            bus.addr_b1 = wr_addr_q;
            bus.din_b1  = wr_data_q;
         end else begin
            bus.cen_b0  = 1'b0;
            bus.wen_b0  = 1'b0;
            bus.addr_b0 = wr_addr_q;
            bus.din_b0  = wr_data_q;
         end
      end
      if (rd_hit) begin
         if (rd_bank_q) begin
            bus.cen_b1  = 1'b0;
            bus.addr_b1 = bus.rd_addr;
         end else begin
            bus.cen_b0  = 1'b0;
            bus.addr_b0 = bus.rd_addr;
         end
      end
   end

   assign bus.ifstore_read_dout = beat;
   assign bus.if_store_busy     = (state_q != IDLE);
   assign bus.if_store_done     = done_q;
   assign bus.bank_full         = bank_full_q;
   assign bus.rd_valid          = rd_valid_q;
   assign bus.rd_data           = rd_valid_q ? (rd_sel_q ? bus.dout_b1 : bus.dout_b0) : '0;

`ifdef IFSRAM_PP_ERR_EN
   logic err_q, err_d;

   always_comb begin
      err_d = err_q
            | (bus.rd_en && !bank_full_q[rd_bank_q])
            | (bus.rd_release && !bank_full_q[rd_bank_q])
            | (bus.start_if_store && (state_q != IDLE));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) err_q <= 1'b0;
      else        err_q <= err_d;
   end

   assign bus.err_sticky = err_q;
`endif
endmodule

// File: doc/ifsram_pingpong_ctrl.md
IFSRAM_PINGPONG_CTRL -- requirements
Module: ifsram_pingpong_ctrl

Interface
REQ-001 Parameter DATA_W, default 64: width of the stream data and of the SRAM word, in bits.
REQ-002 Parameter ADDR_W, default 11: address width of each SRAM bank.
REQ-003 Port list (name, direction, width, meaning):
- clk, in, 1: single clock.
- reset, in, 1: asynchronous, active-low reset.
- start_if_store, in, 1: single-cycle fill request.
- store_len, in, ADDR_W+1: number of words to fill; sampled with start_if_store.
- if_store_busy, out, 1: a fill is accepted and not yet done.
- if_store_done, out, 1: single-cycle pulse at the end of a fill.
- ifstore_data_din, in, DATA_W: stream data.
- ifstore_empty_n_din, in, 1: stream holds valid data.
- ifstore_read_dout, out, 1: stream pop.
- rd_en, in, 1: read request.
- rd_addr, in, ADDR_W: read word address.
- rd_release, in, 1: pulse; the consumer is finished with the current read bank.
- rd_data, out, DATA_W: read data.
- rd_valid, out, 1: rd_data is valid.
- bank_full, out, 2: per-bank "holds a complete tile" flags.
- cen_b0, cen_b1, out, 1 each: SRAM chip enable, active-low.
- wen_b0, wen_b1, out, 1 each: SRAM write enable, active-low.
- addr_b0, addr_b1, out, ADDR_W each: SRAM address.
- din_b0, din_b1, out, DATA_W each: SRAM write data.
- dout_b0, dout_b1, in, DATA_W each: SRAM Q, valid one cycle after a read with CEN low.

Function
REQ-004 The block SHALL keep two registered pointers: wr_bank (the bank to be filled next) and rd_bank (the bank to be consumed next). Both SHALL reset to 0.
REQ-005 The writer FSM SHALL have exactly four states: IDLE, WAIT_BANK, FILL and DONE.
REQ-006 The writer SHALL leave IDLE as follows when start_if_store=1:
- to WAIT_BANK if bank_full[wr_bank]=1;
- to FILL if bank_full[wr_bank]=0;
- to DONE if store_len=0.
REQ-007 In WAIT_BANK the writer SHALL move to FILL in the cycle after bank_full[wr_bank] clears.
REQ-008 ifstore_read_dout SHALL equal (state==FILL && ifstore_empty_n_din && word_cnt<store_len). A beat is accepted only when ifstore_read_dout=1.
REQ-009 An accepted beat SHALL produce a registered SRAM write in the next cycle on bank wr_bank:
- cen=0, wen=0;
- addr = word_cnt (starting at 0);
- din = the beat data.
word_cnt SHALL then increment.
REQ-010 Gaps in ifstore_empty_n_din SHALL stall FILL without losing or duplicating beats.
REQ-011 After the last beat is accepted, the writer SHALL enter DONE.
REQ-012 In DONE the block SHALL:
- pulse if_store_done for exactly one cycle (coincident with the last SRAM write, or the cycle after start when store_len=0);
- set bank_full[wr_bank] and toggle wr_bank, unless store_len=0;
- return to IDLE.
REQ-013 if_store_busy SHALL be 1 in WAIT_BANK, FILL and DONE, and 0 in IDLE. start_if_store while busy SHALL be ignored.
REQ-014 A store_len of 2^ADDR_W SHALL fill the whole bank, with the last address all-ones. word_cnt SHALL NOT wrap inside a fill.
REQ-015 When rd_en=1 and bank_full[rd_bank]=1, bank rd_bank SHALL see, combinationally in the same cycle: cen=0, wen=1, addr=rd_addr.
REQ-016 For such a read, rd_valid SHALL be 1 in the next cycle, and rd_data SHALL equal that bank's dout in that cycle (rd_bank is registered with the request).
REQ-017 rd_en while bank_full[rd_bank]=0 SHALL be ignored: no SRAM access, and rd_valid=0 in the next cycle.
REQ-018 rd_release while bank_full[rd_bank]=1 SHALL clear that flag and toggle rd_bank at the next edge. rd_release while bank_full[rd_bank]=0 SHALL be ignored.
REQ-019 If DONE and rd_release act on the same bank in the same cycle, the release SHALL take priority and the set SHALL be applied one cycle later. By construction this cannot occur, because wr_bank never equals rd_bank while both are active.
REQ-020 A bank not being written or read SHALL be driven with cen=1, wen=1, addr=0, din=0.

Reset
REQ-021 While reset=0, asynchronously:
- the FSM SHALL go to IDLE;
- word_cnt, wr_bank, rd_bank and bank_full SHALL be cleared;
- ifstore_read_dout, if_store_busy, if_store_done and rd_valid SHALL be 0;
- rd_data SHALL be 0;
- all cen and wen SHALL be 1.
REQ-022 A reset during FILL SHALL abandon the fill. Partial bank contents SHALL be treated as invalid (bank_full=0).

Configuration
REQ-023 With IFSRAM_PP_ERR_EN defined, the block SHALL add an output err_sticky (1 bit).
- It SHALL be set on any of: rd_en to a non-full bank, rd_release to a non-full bank, or start_if_store while busy.
- It SHALL be cleared only by reset.
Without IFSRAM_PP_ERR_EN, the port and its logic SHALL be absent, and behaviour is otherwise identical.

Verification
REQ-024 Stimulus: store_len=4, stream 0xA0..0xA3 with no gaps.
Required response: writes to bank0 at addr 0-3; if_store_done pulses once; bank_full=2'b01.
REQ-025 Stimulus: bank0 filled; rd_en with rd_addr=2.
Required response: rd_valid and rd_data=0xA2 one cycle later; then rd_release gives bank_full=0, rd_bank=1.
REQ-026 Stimulus: two fills back-to-back with no release (second fill data 0xB0..0xB3).
Required response: second fill lands in bank1; a third start parks in WAIT_BANK with ifstore_read_dout=0 until rd_release of bank0, then writes bank0.
REQ-027 Stimulus: store_len=8 with ifstore_empty_n_din toggling every cycle.
Required response: exactly 8 writes at addresses 0-7 with data matching stream order.
REQ-028 Stimulus: reset=0 after 3 of 8 beats.
Required response: all outputs at reset values; bank_full=0; a subsequent fill starts at bank0, addr 0.
REQ-029 Stimulus (IFSRAM_PP_ERR_EN defined): rd_en with bank_full=0.
Required response: rd_valid stays 0; err_sticky=1 until reset.
